// File: rtl/core_isa_pkg.sv
// Shared ISA definitions for the 64-bit vector core: opcodes, function codes, width codes,
// instruction field positions (bit 0 = MSB) and the control decode used by the ID stage.
package core_isa_pkg;

  localparam logic [5:0] OP_R_ALU     = 6'b101010;
  localparam logic [5:0] OP_LOAD      = 6'b100000;
  localparam logic [5:0] OP_STORE     = 6'b100001;
  localparam logic [5:0] OP_BRANCH_EZ = 6'b100010;
  localparam logic [5:0] OP_BRANCH_NZ = 6'b100011;
  localparam logic [5:0] OP_NOP       = 6'b111100;

  localparam logic [5:0] F_VNOP   = 6'b000000;
  localparam logic [5:0] F_VAND   = 6'b000001;
  localparam logic [5:0] F_VOR    = 6'b000010;
  localparam logic [5:0] F_VXOR   = 6'b000011;
  localparam logic [5:0] F_VNOT   = 6'b000100;
  localparam logic [5:0] F_VMOV   = 6'b000101;
  localparam logic [5:0] F_VADD   = 6'b000110;
  localparam logic [5:0] F_VSUB   = 6'b000111;
  localparam logic [5:0] F_VMULEU = 6'b001000;
  localparam logic [5:0] F_VMULOU = 6'b001001;
  localparam logic [5:0] F_VSLL   = 6'b001010;
  localparam logic [5:0] F_VSRL   = 6'b001011;
  localparam logic [5:0] F_VSRA   = 6'b001100;
  localparam logic [5:0] F_VRTTH  = 6'b001101;
  localparam logic [5:0] F_VDIV   = 6'b001110;
  localparam logic [5:0] F_VMOD   = 6'b001111;
  localparam logic [5:0] F_VSQEU  = 6'b010000;
  localparam logic [5:0] F_VSQOU  = 6'b010001;
  localparam logic [5:0] F_VSQRT  = 6'b010010;

  localparam logic [1:0] WW_B = 2'b00;
  localparam logic [1:0] WW_H = 2'b01;
  localparam logic [1:0] WW_W = 2'b10;
  localparam logic [1:0] WW_D = 2'b11;

  localparam int OP_MSB  = 0;
  localparam int OP_LSB  = 5;
  localparam int RD_MSB  = 6;
  localparam int RD_LSB  = 10;
  localparam int RA_MSB  = 11;
  localparam int RA_LSB  = 15;
  localparam int RB_MSB  = 16;
  localparam int RB_LSB  = 20;
  localparam int PPP_MSB = 21;
  localparam int PPP_LSB = 23;
  localparam int WW_MSB  = 24;
  localparam int WW_LSB  = 25;
  localparam int FN_MSB  = 26;
  localparam int FN_LSB  = 31;
  localparam int IMM_MSB = 16;
  localparam int IMM_LSB = 31;

  typedef enum logic {ST_RUN, ST_STALL} stage_state_e;

  typedef struct packed {
    logic uses_a;
    logic uses_b;
    logic wr_en;
    logic illegal;
  } dec_ctl_t;

  // Unused read ports must report uses_* = 0 so they never raise a hazard.
  function automatic dec_ctl_t decode_ctl(input logic [5:0] op, input logic [5:0] fn);
    dec_ctl_t d;
    d = '0;
    case (op)
      OP_R_ALU: begin
        d.uses_a = (fn != F_VNOP);
        d.uses_b = !(fn inside {F_VNOT, F_VMOV, F_VSQRT, F_VNOP});
        d.wr_en  = (fn != F_VNOP);
      end
      OP_LOAD: begin
        d.uses_a = 1'b1;
        d.wr_en  = 1'b1;
      end
      OP_STORE: begin
        d.uses_a = 1'b1;
        d.uses_b = 1'b1;
      end
      OP_BRANCH_EZ, OP_BRANCH_NZ: d.uses_b = 1'b1;
      OP_NOP: d = '0;
      default: d.illegal = 1'b1;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/operand_bypass.sv
// Per-read-port operand resolution: EX/MEM result beats WB data beats register-file data.
// Also reports raw address matches against the ID/EX and EX/MEM destinations for hazard checks.
module operand_bypass #(
  parameter int DW  = 64,
  parameter int RAW = 5
) (
  input  logic [RAW-1:0] addr,
  input  logic [0:DW-1]  rf_data,
  input  logic           exm_fwd_en,
  input  logic [RAW-1:0] exm_rd,
  input  logic [0:DW-1]  exm_data,
  input  logic           wb_wr_en,
  input  logic [RAW-1:0] wb_rd,
  input  logic [0:DW-1]  wb_data,
  input  logic [RAW-1:0] idex_rd,
  output logic [0:DW-1]  val,
  output logic           exm_match,
  output logic           idex_match
);

  assign exm_match  = (exm_rd == addr);
  assign idex_match = (idex_rd == addr);

  always_comb begin
    val = rf_data;
    if (exm_fwd_en && exm_match) begin
      val = exm_data;
    end else if (wb_wr_en && (wb_rd == addr)) begin
      val = wb_data;
    end
  end

endmodule

// File: rtl/id_ex_stage.sv
// Decode stage plus ID/EX pipeline register with operand bypass and hazard stall.
// Define ID_EX_FWD_EN to enable the EX/MEM bypass path; otherwise any EX/MEM writer of a source stalls.
module id_ex_stage
  import core_isa_pkg::*;
#(
  parameter int DW  = 64,
  parameter int IW  = 32,
  parameter int RAW = 5
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           if_valid,
  output logic           if_ready,
  input  logic [0:IW-1]  if_instr,
  output logic [RAW-1:0] rf_a_addr,
  output logic [RAW-1:0] rf_b_addr,
  input  logic [0:DW-1]  rf_a_data,
  input  logic [0:DW-1]  rf_b_data,
  input  logic           exm_wr_en,
  input  logic [RAW-1:0] exm_rd,
  input  logic [0:DW-1]  exm_data,
  input  logic           exm_is_load,
  input  logic           wb_wr_en,
  input  logic [RAW-1:0] wb_rd,
  input  logic [0:DW-1]  wb_data,
  input  logic           ex_ready,
  output logic           idex_valid,
  output logic [5:0]     idex_opcode,
  output logic [5:0]     idex_rins,
  output logic [1:0]     idex_ww,
  output logic [2:0]     idex_ppp,
  output logic [RAW-1:0] idex_rd,
  output logic [0:DW-1]  idex_a_val,
  output logic [0:DW-1]  idex_b_val,
  output logic [15:0]    idex_imm,
  output logic           idex_wr_en,
  output logic           idex_illegal
);

  logic [5:0]     f_op;
  logic [5:0]     f_fn;
  logic [RAW-1:0] f_rd;
  logic [RAW-1:0] f_ra;
  logic [RAW-1:0] f_rb;
  logic [2:0]     f_ppp;
  logic [1:0]     f_ww;
  logic [15:0]    f_imm;
  dec_ctl_t       ctl;

  assign f_op  = if_instr[OP_MSB:OP_LSB];
  assign f_rd  = if_instr[RD_MSB:RD_LSB];
  assign f_ra  = if_instr[RA_MSB:RA_LSB];
  assign f_rb  = if_instr[RB_MSB:RB_LSB];
  assign f_ppp = if_instr[PPP_MSB:PPP_LSB];
  assign f_ww  = if_instr[WW_MSB:WW_LSB];
  assign f_fn  = if_instr[FN_MSB:FN_LSB];
  assign f_imm = if_instr[IMM_MSB:IMM_LSB];
  assign ctl   = decode_ctl(f_op, f_fn);

  // Stores and branches read their data/test value from rD through port B.
  assign rf_a_addr = f_ra;
  assign rf_b_addr = (f_op == OP_STORE || f_op == OP_BRANCH_EZ || f_op == OP_BRANCH_NZ) ? f_rd : f_rb;

  logic exm_fwd_en;
  logic exm_block;

`ifdef ID_EX_FWD_EN
  assign exm_fwd_en = exm_wr_en && !exm_is_load;
  assign exm_block  = exm_is_load;
`else
  assign exm_fwd_en = 1'b0;
  assign exm_block  = exm_wr_en || exm_is_load;
`endif

  logic [0:DW-1] a_val;
  logic [0:DW-1] b_val;
  logic          a_exm_match;
  logic          a_idex_match;
  logic          b_exm_match;
  logic          b_idex_match;

  operand_bypass #(.DW(DW), .RAW(RAW)) u_bypass_a (
    .addr       (rf_a_addr),
    .rf_data    (rf_a_data),
    .exm_fwd_en (exm_fwd_en),
    .exm_rd     (exm_rd),
    .exm_data   (exm_data),
    .wb_wr_en   (wb_wr_en),
    .wb_rd      (wb_rd),
    .wb_data    (wb_data),
    .idex_rd    (idex_rd),
    .val        (a_val),
    .exm_match  (a_exm_match),
    .idex_match (a_idex_match)
  );

  operand_bypass #(.DW(DW), .RAW(RAW)) u_bypass_b (
    .addr       (rf_b_addr),
    .rf_data    (rf_b_data),
    .exm_fwd_en (exm_fwd_en),
    .exm_rd     (exm_rd),
    .exm_data   (exm_data),
    .wb_wr_en   (wb_wr_en),
    .wb_rd      (wb_rd),
    .wb_data    (wb_data),
    .idex_rd    (idex_rd),
    .val        (b_val),
    .exm_match  (b_exm_match),
    .idex_match (b_idex_match)
  );

  logic idex_block;
  logic src_hazard;
  logic stall_req;
  logic hold;
  logic accept;

  // The ALU output has no bypass path, so a producer still sitting in ID/EX always stalls.
  assign idex_block = idex_valid && idex_wr_en;
  assign src_hazard = (ctl.uses_a && ((idex_block && a_idex_match) || (exm_block && a_exm_match))) ||
                      (ctl.uses_b && ((idex_block && b_idex_match) || (exm_block && b_exm_match)));
  assign stall_req  = if_valid && src_hazard;
  assign hold       = idex_valid && !ex_ready;
  assign if_ready   = rst_n && !hold && !src_hazard;
  assign accept     = if_valid && if_ready;

  stage_state_e state;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= ST_RUN;
      idex_valid   <= 1'b0;
      idex_opcode  <= '0;
      idex_rins    <= '0;
      idex_ww      <= '0;
      idex_ppp     <= '0;
      idex_rd      <= '0;
      idex_a_val   <= '0;
      idex_b_val   <= '0;
      idex_imm     <= '0;
      idex_wr_en   <= 1'b0;
      idex_illegal <= 1'b0;
    end else if (!hold) begin
      idex_valid <= accept;
      if (accept) begin
        idex_opcode  <= f_op;
        idex_rins    <= f_fn;
        idex_ww      <= f_ww;
        idex_ppp     <= f_ppp;
        idex_rd      <= f_rd;
        idex_a_val   <= a_val;
        idex_b_val   <= b_val;
        idex_imm     <= f_imm;
        idex_wr_en   <= ctl.wr_en;
        idex_illegal <= ctl.illegal;
      end
      case (state)
        ST_RUN:   if (stall_req) state <= ST_STALL;
        ST_STALL: if (!stall_req) state <= ST_RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage: directed stimulus pushes expected bundles, a negedge monitor pops
// and compares each bundle as it leaves. Expectations follow ID_EX_FWD_EN when that macro is defined.
module tb_id_ex_stage;
  import core_isa_pkg::*;

  localparam logic [63:0] R0   = 64'h0F0F_0F0F_0F0F_0F0F;
  localparam logic [63:0] R1   = 64'h0102_0304_0506_0708;
  localparam logic [63:0] R2   = 64'h0101_0101_0101_0101;
  localparam logic [63:0] R3   = 64'h3333_3333_3333_3333;
  localparam logic [63:0] R5   = 64'h0505_0505_A0A0_A0A0;
  localparam logic [63:0] R7   = 64'h7777_7777_7777_7777;
  localparam logic [63:0] R12  = 64'hC0C0_C0C0_0000_000C;
  localparam logic [63:0] DEAD = 64'hDEAD_BEEF_0000_0001;
  localparam logic [63:0] LDV  = 64'h55AA_55AA_55AA_55AA;
  localparam logic [63:0] EXV  = 64'h1111_1111_1111_1111;
  localparam logic [63:0] WBV  = 64'h2222_2222_2222_2222;
`ifdef ID_EX_FWD_EN
  localparam logic [63:0] PRIO_EXP = EXV;
`else
  localparam logic [63:0] PRIO_EXP = WBV;
`endif

  logic        clk;
  logic        rst_n;
  logic        if_valid;
  logic        if_ready;
  logic [0:31] if_instr;
  logic [4:0]  rf_a_addr;
  logic [4:0]  rf_b_addr;
  logic [0:63] rf_a_data;
  logic [0:63] rf_b_data;
  logic        exm_wr_en;
  logic [4:0]  exm_rd;
  logic [0:63] exm_data;
  logic        exm_is_load;
  logic        wb_wr_en;
  logic [4:0]  wb_rd;
  logic [0:63] wb_data;
  logic        ex_ready;
  logic        idex_valid;
  logic [5:0]  idex_opcode;
  logic [5:0]  idex_rins;
  logic [1:0]  idex_ww;
  logic [2:0]  idex_ppp;
  logic [4:0]  idex_rd;
  logic [0:63] idex_a_val;
  logic [0:63] idex_b_val;
  logic [15:0] idex_imm;
  logic        idex_wr_en;
  logic        idex_illegal;

  logic [63:0] rf [32];
  assign rf_a_data = rf[rf_a_addr];
  assign rf_b_data = rf[rf_b_addr];

  id_ex_stage dut (
    .clk(clk), .rst_n(rst_n), .if_valid(if_valid), .if_ready(if_ready), .if_instr(if_instr),
    .rf_a_addr(rf_a_addr), .rf_b_addr(rf_b_addr), .rf_a_data(rf_a_data), .rf_b_data(rf_b_data),
    .exm_wr_en(exm_wr_en), .exm_rd(exm_rd), .exm_data(exm_data), .exm_is_load(exm_is_load),
    .wb_wr_en(wb_wr_en), .wb_rd(wb_rd), .wb_data(wb_data), .ex_ready(ex_ready),
    .idex_valid(idex_valid), .idex_opcode(idex_opcode), .idex_rins(idex_rins), .idex_ww(idex_ww),
    .idex_ppp(idex_ppp), .idex_rd(idex_rd), .idex_a_val(idex_a_val), .idex_b_val(idex_b_val),
    .idex_imm(idex_imm), .idex_wr_en(idex_wr_en), .idex_illegal(idex_illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          id;
    logic [5:0]  op;
    logic [5:0]  rins;
    logic [1:0]  ww;
    logic [2:0]  ppp;
    logic [4:0]  rd;
    logic [63:0] a;
    logic [63:0] b;
    logic [15:0] imm;
    logic        wr;
    logic        ill;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic push(input int id, input logic [5:0] op, input logic [5:0] rins, input logic [1:0] ww,
                      input logic [2:0] ppp, input logic [4:0] rd, input logic [63:0] a,
                      input logic [63:0] b, input logic [15:0] imm, input logic wr, input logic ill);
    exp_t e;
    e.id = id; e.op = op; e.rins = rins; e.ww = ww; e.ppp = ppp; e.rd = rd;
    e.a = a; e.b = b; e.imm = imm; e.wr = wr; e.ill = ill;
    exp_q.push_back(e);
  endtask

  function automatic logic [31:0] mk(input logic [5:0] op, input logic [4:0] rd, input logic [4:0] ra,
                                     input logic [4:0] rb, input logic [2:0] ppp, input logic [1:0] ww,
                                     input logic [5:0] fn);
    return {op, rd, ra, rb, ppp, ww, fn};
  endfunction

  function automatic logic [31:0] mki(input logic [5:0] op, input logic [4:0] rd, input logic [4:0] ra,
                                      input logic [15:0] imm);
    return {op, rd, ra, imm};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [31:0] instr);
    if_valid = 1'b1;
    if_instr = instr;
  endtask

  task automatic idle();
    if_valid = 1'b0;
  endtask

  // Monitor: a bundle leaves whenever valid && ex_ready at the coming edge.
  always @(negedge clk) begin
    if (rst_n && idex_valid && ex_ready) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("[TB] FAIL unexpected_bundle: got opcode %b rd %0d, expected no bundle", idex_opcode, idex_rd);
      end else begin
        mon_e = exp_q.pop_front();
        checkOutput($sformatf("b%0d_opcode", mon_e.id), 64'(idex_opcode), 64'(mon_e.op));
        checkOutput($sformatf("b%0d_rins", mon_e.id), 64'(idex_rins), 64'(mon_e.rins));
        checkOutput($sformatf("b%0d_ww", mon_e.id), 64'(idex_ww), 64'(mon_e.ww));
        checkOutput($sformatf("b%0d_ppp", mon_e.id), 64'(idex_ppp), 64'(mon_e.ppp));
        checkOutput($sformatf("b%0d_rd", mon_e.id), 64'(idex_rd), 64'(mon_e.rd));
        checkOutput($sformatf("b%0d_a_val", mon_e.id), idex_a_val, mon_e.a);
        checkOutput($sformatf("b%0d_b_val", mon_e.id), idex_b_val, mon_e.b);
        checkOutput($sformatf("b%0d_imm", mon_e.id), 64'(idex_imm), 64'(mon_e.imm));
        checkOutput($sformatf("b%0d_wr_en", mon_e.id), 64'(idex_wr_en), 64'(mon_e.wr));
        checkOutput($sformatf("b%0d_illegal", mon_e.id), 64'(idex_illegal), 64'(mon_e.ill));
      end
    end
  end

  initial begin
    for (int i = 0; i < 32; i++) rf[i] = 64'hFFFF_0000_0000_0000 | 64'(i);
    rf[0] = R0; rf[1] = R1; rf[2] = R2; rf[3] = R3; rf[5] = R5; rf[7] = R7; rf[12] = R12;
    rst_n = 1'b0; ex_ready = 1'b1;
    exm_wr_en = 1'b0; exm_rd = '0; exm_data = '0; exm_is_load = 1'b0;
    wb_wr_en = 1'b0; wb_rd = '0; wb_data = '0;
    applyStimulus(mk(OP_R_ALU, 5'd3, 5'd1, 5'd2, 3'd0, WW_B, F_VADD));

    // Reset with fetch offering an instruction
    step(); step(); #1;
    checkOutput("rst_if_ready", 64'(if_ready), 64'd0);
    checkOutput("rst_valid", 64'(idex_valid), 64'd0);
    checkOutput("rst_opcode", 64'(idex_opcode), 64'd0);
    checkOutput("rst_rd", 64'(idex_rd), 64'd0);
    checkOutput("rst_a_val", idex_a_val, 64'd0);
    checkOutput("rst_b_val", idex_b_val, 64'd0);
    checkOutput("rst_imm", 64'(idex_imm), 64'd0);
    checkOutput("rst_wr_en", 64'(idex_wr_en), 64'd0);
    rst_n = 1'b1; idle();
    step();

    // Plain VADD r3,r1,r2
    applyStimulus(mk(OP_R_ALU, 5'd3, 5'd1, 5'd2, 3'd0, WW_B, F_VADD)); #1;
    checkOutput("t2_if_ready", 64'(if_ready), 64'd1);
    push(1, OP_R_ALU, F_VADD, WW_B, 3'd0, 5'd3, R1, R2, 16'h1006, 1'b1, 1'b0);
    step(); idle(); step();

    // ALU-to-ALU RAW: VADD r3 then VSUB r4,r3,r5
    applyStimulus(mk(OP_R_ALU, 5'd3, 5'd1, 5'd2, 3'd0, WW_B, F_VADD)); #1;
    push(2, OP_R_ALU, F_VADD, WW_B, 3'd0, 5'd3, R1, R2, 16'h1006, 1'b1, 1'b0);
    step();
    applyStimulus(mk(OP_R_ALU, 5'd4, 5'd3, 5'd5, 3'd0, WW_B, F_VSUB)); #1;
    checkOutput("t3_idex_raw_stall", 64'(if_ready), 64'd0);
    step();
    exm_wr_en = 1'b1; exm_rd = 5'd3; exm_data = DEAD; #1;
`ifdef ID_EX_FWD_EN
    checkOutput("t3_fwd_go", 64'(if_ready), 64'd1);
    push(3, OP_R_ALU, F_VSUB, WW_B, 3'd0, 5'd4, DEAD, R5, 16'h2807, 1'b1, 1'b0);
    step();
    exm_wr_en = 1'b0; idle();
`else
    checkOutput("t3_exm_stall", 64'(if_ready), 64'd0);
    step();
    exm_wr_en = 1'b0; wb_wr_en = 1'b1; wb_rd = 5'd3; wb_data = DEAD; #1;
    checkOutput("t3_wb_go", 64'(if_ready), 64'd1);
    push(3, OP_R_ALU, F_VSUB, WW_B, 3'd0, 5'd4, DEAD, R5, 16'h2807, 1'b1, 1'b0);
    step();
    wb_wr_en = 1'b0; idle();
`endif
    step();

    // Load-use: LOAD r7 in EX/MEM, VAND r8,r7,r7
    exm_wr_en = 1'b1; exm_rd = 5'd7; exm_is_load = 1'b1; exm_data = 64'hBAD0_BAD0_BAD0_BAD0;
    applyStimulus(mk(OP_R_ALU, 5'd8, 5'd7, 5'd7, 3'd0, WW_B, F_VAND)); #1;
    checkOutput("t4_load_stall", 64'(if_ready), 64'd0);
    step();
    exm_wr_en = 1'b0; exm_is_load = 1'b0; wb_wr_en = 1'b1; wb_rd = 5'd7; wb_data = LDV; #1;
    checkOutput("t4_wb_go", 64'(if_ready), 64'd1);
    push(4, OP_R_ALU, F_VAND, WW_B, 3'd0, 5'd8, LDV, LDV, 16'h3801, 1'b1, 1'b0);
    step();
    wb_wr_en = 1'b0; idle(); step();

    // Back-pressure: bundle held for 3 cycles while the next instruction waits
    applyStimulus(mk(OP_R_ALU, 5'd9, 5'd1, 5'd2, 3'd3, WW_W, F_VXOR)); #1;
    push(5, OP_R_ALU, F_VXOR, WW_W, 3'd3, 5'd9, R1, R2, 16'h1383, 1'b1, 1'b0);
    step();
    ex_ready = 1'b0;
    applyStimulus(mk(OP_R_ALU, 5'd10, 5'd5, 5'd2, 3'd0, WW_B, F_VOR));
    for (int i = 0; i < 3; i++) begin
      #1;
      checkOutput($sformatf("t5_hold%0d_if_ready", i), 64'(if_ready), 64'd0);
      checkOutput($sformatf("t5_hold%0d_valid", i), 64'(idex_valid), 64'd1);
      checkOutput($sformatf("t5_hold%0d_a_val", i), idex_a_val, R1);
      checkOutput($sformatf("t5_hold%0d_rd", i), 64'(idex_rd), 64'd9);
      step();
    end
    ex_ready = 1'b1; #1;
    checkOutput("t5_release", 64'(if_ready), 64'd1);
    push(6, OP_R_ALU, F_VOR, WW_B, 3'd0, 5'd10, R5, R2, 16'h1002, 1'b1, 1'b0);
    step(); idle(); step();

    // Illegal opcode (rd=1, so wr_en=0 must suppress the hazard for the following VADD), then NOP, STORE
    applyStimulus(mk(6'b000111, 5'd1, 5'd1, 5'd2, 3'd0, WW_B, F_VADD)); #1;
    push(7, 6'b000111, F_VADD, WW_B, 3'd0, 5'd1, R1, R2, 16'h1006, 1'b0, 1'b1);
    step();
    applyStimulus(mk(OP_R_ALU, 5'd12, 5'd1, 5'd2, 3'd0, WW_B, F_VADD)); #1;
    checkOutput("t6_illegal_no_hazard", 64'(if_ready), 64'd1);
    push(8, OP_R_ALU, F_VADD, WW_B, 3'd0, 5'd12, R1, R2, 16'h1006, 1'b1, 1'b0);
    step();
    applyStimulus(mk(OP_NOP, 5'd12, 5'd12, 5'd12, 3'd0, WW_B, F_VNOP)); #1;
    checkOutput("t6_nop_no_hazard", 64'(if_ready), 64'd1);
    push(9, OP_NOP, F_VNOP, WW_B, 3'd0, 5'd12, R12, R12, 16'h6000, 1'b0, 1'b0);
    step();
    applyStimulus(mki(OP_STORE, 5'd5, 5'd1, 16'h0040)); #1;
    checkOutput("t6_store_go", 64'(if_ready), 64'd1);
    push(10, OP_STORE, F_VNOP, WW_H, 3'd0, 5'd5, R1, R5, 16'h0040, 1'b0, 1'b0);
    step(); idle(); step();

    // Bypass priority on r1: EX/MEM over WB when forwarding exists
`ifdef ID_EX_FWD_EN
    exm_wr_en = 1'b1; exm_rd = 5'd1; exm_data = EXV;
`endif
    wb_wr_en = 1'b1; wb_rd = 5'd1; wb_data = WBV;
    applyStimulus(mk(OP_R_ALU, 5'd13, 5'd1, 5'd0, 3'd0, WW_B, F_VMOV)); #1;
    checkOutput("t7_prio_go", 64'(if_ready), 64'd1);
    push(11, OP_R_ALU, F_VMOV, WW_B, 3'd0, 5'd13, PRIO_EXP, R0, 16'h0005, 1'b1, 1'b0);
    step();
    exm_wr_en = 1'b0; wb_wr_en = 1'b0; idle(); step();

    // Reset in the middle of a load-use stall drops the held instruction
    exm_wr_en = 1'b1; exm_rd = 5'd7; exm_is_load = 1'b1;
    applyStimulus(mk(OP_R_ALU, 5'd8, 5'd7, 5'd7, 3'd0, WW_B, F_VAND)); #1;
    checkOutput("t8_stall", 64'(if_ready), 64'd0);
    step();
    exm_wr_en = 1'b0; exm_is_load = 1'b0; rst_n = 1'b0; #1;
    checkOutput("t8_if_ready_in_reset", 64'(if_ready), 64'd0);
    step();
    rst_n = 1'b1; idle(); #1;
    checkOutput("t8_valid_after_reset", 64'(idex_valid), 64'd0);
    step(); step();
    checkOutput("t8_valid_later", 64'(idex_valid), 64'd0);

    step(); step();
    checkOutput("drain_queue", 64'(exp_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
